// File: rtl/pc_fetch.sv
// pc_fetch -- instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the PC and drives a synchronous-read instruction SRAM with a 1-cycle
// read latency. Every cycle it presents the previous cycle's request
// (if_pc/if_inst) to IF/ID and issues the next request.
//
// Next-request priority: flush > stall[0] > branch > pending branch > pc+PC_INC.
// Branches use delay-slot semantics, so the fetch already in flight is never
// killed. While stalled, the returned instruction is buffered in hold_q so
// the SRAM is never re-read.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall[5:0]        pipeline stall vector; only bit 0 (PC/IF) is used here
//   flush, new_pc     exception-unit redirect, highest priority
//   branch_flag_i     taken branch/jump from ID
//   branch_target_i   its target address
//   inst_sram_*       SRAM request (en/wen/addr) and returned data (rdata)
//   if_pc, if_inst    instruction presented to IF/ID (if_inst=0 when invalid)
//   if_valid          if_pc/if_inst carry a real instruction
//   if_excp_adel      fetch address error
//   dbg_state         current FSM state (BOOT=0, RUN=1, HOLD=2)
//
// Optional feature: define IF_ADDR_ALIGN_CHECK_EN to trap misaligned fetch
// addresses. A misaligned address is not sent to the SRAM; the next cycle
// reports it on if_excp_adel, and fetch parks there until a flush. Without
// the macro, if_excp_adel stays 0 and address bits [1:0] go to the SRAM as-is.
//
// Handshake: there is no valid/ready pair. Each cycle with if_valid=1 is
// one instruction offered to IF/ID. stall[0]=1 means IF/ID did not take it,
// so the same if_pc/if_inst is offered again until stall[0] falls.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_excp_adel,
  output logic [1:0]  dbg_state
);

`ifdef IF_ADDR_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic        adel_q, adel_d;   // pc_q is a misaligned address that was never fetched

  logic        req;
  logic [31:0] req_addr;
  logic [31:0] seq_addr;
  logic        req_bad;

  // Only stall[0] concerns the fetch stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign inst_sram_wen = 4'b0000;
  assign dbg_state     = state_q;

  // Address for a normal (non-flush) advance: a live branch beats a pending one.
  assign seq_addr = branch_flag_i ? branch_target_i :
                    br_pend_q     ? br_tgt_q        :
                                    pc_q + PC_INC;

  assign req_bad = ALIGN_CHECK && (req_addr[1:0] != 2'b00);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_d         = hold_q;
    br_pend_d      = br_pend_q;
    br_tgt_d       = br_tgt_q;
    adel_d         = adel_q;
    req            = 1'b0;
    req_addr       = 32'h0;
    inst_sram_en   = 1'b0;
    inst_sram_addr = 32'h0;
    if_pc          = 32'h0;
    if_inst        = 32'h0;
    if_valid       = 1'b0;
    if_excp_adel   = 1'b0;

    // Outputs are held at 0 during reset; the registers reset in always_ff.
    if (!rst) begin
      case (state_q)
        BOOT: begin
          req      = 1'b1;
          req_addr = RESET_PC;
          state_d  = RUN;
        end

        RUN, HOLD: begin
          if_pc    = pc_q;
          if_valid = 1'b1;
          if (adel_q) begin
            if_excp_adel = 1'b1;
          end else begin
            if_inst = (state_q == HOLD) ? hold_q : inst_sram_rdata;
          end

          if (flush) begin
            // The data returning this cycle is squashed; the redirect is
            // issued now, so the next cycle's data is already the new stream.
            req          = 1'b1;
            req_addr     = new_pc;
            br_pend_d    = 1'b0;
            state_d      = RUN;
            if_valid     = 1'b0;
            if_inst      = 32'h0;
            if_excp_adel = 1'b0;
          end else if (adel_q) begin
            // Parked on a faulting address until a flush arrives.
            state_d = RUN;
          end else if (stall[0]) begin
            if (state_q == RUN) begin
              hold_d = inst_sram_rdata;
            end
            state_d = HOLD;
            if (branch_flag_i) begin
              br_pend_d = 1'b1;
              br_tgt_d  = branch_target_i;
            end
          end else begin
            req       = 1'b1;
            req_addr  = seq_addr;
            br_pend_d = 1'b0;
            state_d   = RUN;
          end
        end

        default: state_d = BOOT;
      endcase

      if (req) begin
        inst_sram_en   = !req_bad;
        inst_sram_addr = req_addr;
        pc_d           = req_addr;
        adel_d         = req_bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= 32'h0;
      hold_q    <= 32'h0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= 32'h0;
      adel_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
      adel_q    <= adel_d;
    end
  end

endmodule
